// File: rtl/qspi_mem_arbiter.sv
// QSPI master for the flash / RAM-A / RAM-B PMOD.
// Arbitrates instruction-fetch and data-port requests, then serialises each one
// onto the shared 4-bit bus as command, address, dummy and data nibbles.
// The bus clock runs at clk/2: every nibble slot is one low cycle then one high cycle.
// All pin outputs are registered, so the pins carry no decode glitches.
//
// Handshake: a requester raises req with its operands and holds it until it
// sees its one-cycle ack. Operands are latched in the accept cycle, so later
// changes are ignored. A req that is still high in the cycle after the ack is
// taken as a new request.
module qspi_mem_arbiter #(
  parameter int DUMMY_NIBBLES = 4,   // read dummy slots; must be >= 1
  parameter int ADDR_BITS     = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req,
  input  logic [24:0] instr_addr,
  output logic        instr_ack,
  output logic [31:0] instr_rdata,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [24:0] data_addr,
  input  logic [1:0]  data_len,
  input  logic [31:0] data_wdata,
  output logic        data_ack,
  output logic        data_err,
  output logic [31:0] data_rdata,
  output logic        qspi_clk,
  output logic        qspi_flash_select,
  output logic        qspi_ram_a_select,
  output logic        qspi_ram_b_select,
  output logic [3:0]  qspi_data_out,
  output logic [3:0]  qspi_data_oe,
  input  logic [3:0]  qspi_data_in
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE} state_t;

  localparam int CW = 8;
  localparam logic [1:0] DEV_FLASH = 2'd0;
  localparam logic [1:0] DEV_RAM_A = 2'd1;
  localparam logic [1:0] DEV_RAM_B = 2'd2;
  localparam logic [CW-1:0] ADDR_LAST  = CW'(ADDR_BITS / 4 - 1);
  localparam logic [CW-1:0] DUMMY_LAST = CW'(DUMMY_NIBBLES - 1);

  // Bit offset of data nibble k inside a little-endian word (high nibble of each byte first).
  function automatic logic [4:0] nib_shift(input logic [2:0] k);
    return {k[2:1], ~k[0], 2'b00};
  endfunction

  state_t          state_q, state_d, state_after;
  logic [CW-1:0]   slot_q, slot_d, slot_last;
  logic            phase_q, phase_d;
  logic            port_q, port_d;       // 1 = data port, 0 = instr port
  logic            we_q, we_d;
  logic            err_q, err_d;
  logic [1:0]      dev_q, dev_d;
  logic [1:0]      len_q, len_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rbuf_q, rbuf_d;
  logic            fair_q, fair_d;
  logic            clk_q, clk_d;
  logic [2:0]      sel_n_q, sel_n_d;     // index = device code
  logic [3:0]      dout_q, dout_d;
  logic            oe_q, oe_d;

  logic            gnt_data, gnt_instr, data_reject, bus_d;
  logic [7:0]      cmd_byte;
  logic [CW+1:0]   addr_rsh;
  logic            unused_instr_bit;

  // Bit 24 of a fetch address is a requester bug and is simply dropped.
  assign unused_instr_bit = instr_addr[24];

  // Data wins a tie unless a fetch was already passed over once.
  assign gnt_data    = (state_q == S_IDLE) && data_req && !(instr_req && fair_q);
  assign gnt_instr   = (state_q == S_IDLE) && instr_req && !gnt_data;
  assign data_reject = (data_len == 2'd2) || (data_we && !data_addr[24]);

  // Per-phase slot count and successor state.
  always_comb begin
    slot_last   = '0;
    state_after = S_IDLE;
    case (state_q)
      S_CMD:   begin slot_last = CW'(1);     state_after = S_ADDR; end
      S_ADDR:  begin
        slot_last   = ADDR_LAST;
        state_after = (we_q || DUMMY_NIBBLES == 0) ? S_DATA : S_DUMMY;
      end
      S_DUMMY: begin slot_last = DUMMY_LAST; state_after = S_DATA; end
      S_DATA:  begin slot_last = {{(CW-3){1'b0}}, len_q, 1'b1}; state_after = S_DONE; end
      default: ;
    endcase
  end

  // Next-state, transaction latches, read capture, then next pin values.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    phase_d = phase_q;
    port_d  = port_q;
    we_d    = we_q;
    err_d   = err_q;
    dev_d   = dev_q;
    len_d   = len_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rbuf_d  = rbuf_q;
    fair_d  = fair_q;

    case (state_q)
      S_IDLE: begin
        if (gnt_data) begin
          port_d  = 1'b1;
          we_d    = data_we;
          len_d   = data_len;
          wdata_d = data_wdata;
          err_d   = data_reject;
          if (!data_addr[24]) begin
            dev_d  = DEV_FLASH;
            addr_d = ADDR_BITS'(data_addr[23:0]);
          end else begin
            dev_d  = data_addr[23] ? DEV_RAM_B : DEV_RAM_A;
            addr_d = ADDR_BITS'(data_addr[22:0]);
          end
          if (instr_req) fair_d = 1'b1;
        end else if (gnt_instr) begin
          port_d  = 1'b0;
          we_d    = 1'b0;
          len_d   = 2'd3;
          wdata_d = data_wdata;
          err_d   = 1'b0;
          dev_d   = DEV_FLASH;
          addr_d  = ADDR_BITS'(instr_addr[23:0]);
          fair_d  = 1'b0;
        end
        if (gnt_data || gnt_instr) begin
          rbuf_d  = '0;
          slot_d  = '0;
          phase_d = 1'b0;
          state_d = err_d ? S_DONE : S_CMD;
        end
      end
      S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
        phase_d = ~phase_q;
        if (state_q == S_DATA && phase_q && !we_q)
          rbuf_d = rbuf_q | ({28'd0, qspi_data_in} << nib_shift(slot_q[2:0]));
        if (phase_q) begin
          if (slot_q == slot_last) begin
            slot_d  = '0;
            state_d = state_after;
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    bus_d    = (state_d == S_CMD) || (state_d == S_ADDR) ||
               (state_d == S_DUMMY) || (state_d == S_DATA);
    sel_n_d  = 3'b111;
    if (bus_d) sel_n_d[dev_d] = 1'b0;
    clk_d    = bus_d & phase_d;
    cmd_byte = we_d ? 8'h02 : 8'h0B;
    addr_rsh = (CW+2)'(ADDR_BITS - 4) - {slot_d, 2'b00};
    dout_d   = '0;
    oe_d     = 1'b0;
    case (state_d)
      S_CMD: begin
        dout_d = slot_d[0] ? cmd_byte[3:0] : cmd_byte[7:4];
        oe_d   = 1'b1;
      end
      S_ADDR: begin
        dout_d = 4'(addr_d >> addr_rsh);
        oe_d   = 1'b1;
      end
      S_DATA: begin
        if (we_d) begin
          dout_d = 4'(wdata_d >> nib_shift(slot_d[2:0]));
          oe_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State and pin registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
      phase_q <= 1'b0;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      dev_q   <= DEV_FLASH;
      len_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      fair_q  <= 1'b0;
      clk_q   <= 1'b0;
      sel_n_q <= 3'b111;
      dout_q  <= '0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      phase_q <= phase_d;
      port_q  <= port_d;
      we_q    <= we_d;
      err_q   <= err_d;
      dev_q   <= dev_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rbuf_q  <= rbuf_d;
      fair_q  <= fair_d;
      clk_q   <= clk_d;
      sel_n_q <= sel_n_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
    end
  end

  assign instr_ack         = (state_q == S_DONE) && !port_q;
  assign data_ack          = (state_q == S_DONE) && port_q;
  assign data_err          = data_ack && err_q;
  assign instr_rdata       = rbuf_q;
  assign data_rdata        = rbuf_q;
  assign qspi_clk          = clk_q;
  assign qspi_flash_select = sel_n_q[DEV_FLASH];
  assign qspi_ram_a_select = sel_n_q[DEV_RAM_A];
  assign qspi_ram_b_select = sel_n_q[DEV_RAM_B];
  assign qspi_data_out     = dout_q;
  assign qspi_data_oe      = {4{oe_q}};

endmodule
